// File: rtl/therm_sample_ctrl_if.sv
// ADC handshake bundle for therm_sample_ctrl (controller = master, ADC = slave).
// adc_start is a one-cycle request; adc_done qualifies adc_data and is only
// looked at by the controller while it is waiting for a result.
interface therm_sample_ctrl_if #(
  parameter int VW = 12
) ();
  logic          adc_start;
  logic          adc_done;
  logic [VW-1:0] adc_data;

  modport master (
    output adc_start,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  adc_start,
    output adc_done,
    output adc_data
  );
endinterface

// File: rtl/therm_sample_ctrl.sv
// Thermistor sampling sequencer: timer-paced ADC bursts, averaging, converter hand-off.
// Optional over-temperature alarm with hysteresis is built when THERM_ALARM_EN is defined.
module therm_sample_ctrl #(
  parameter int VW       = 12,
  parameter int TW       = 8,
  parameter int PERIOD   = 1000,
  parameter int LOG2_AVG = 2,
  parameter int TIMEOUT  = 64,
  parameter int ALARM_HI = 85,
  parameter int ALARM_LO = 80
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  therm_sample_ctrl_if.master  adc,
  output logic [VW-1:0]        v_therm,
  input  logic [TW-1:0]        temp_therm,
  output logic [TW-1:0]        temp,
  output logic                 temp_valid,
  output logic                 busy,
  output logic                 adc_err,
  input  logic                 err_clr,
  output logic                 over_temp,
  output logic [2:0]           dbg_state
);

  localparam int NS  = 1 << LOG2_AVG;
  localparam int AW  = VW + LOG2_AVG;
  localparam int CW  = LOG2_AVG + 1;
  localparam int TMW = $clog2(PERIOD);
  localparam int TOW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    CONVERT   = 3'd3,
    SETTLE    = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [TMW-1:0]  timer;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [TOW-1:0]  tmo_cnt;
  logic            tick;

  logic acc_add, burst_clr, tmo_clr, tmo_inc, load_v, publish, set_err;

  assign tick = enable && (timer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= TMW'(PERIOD - 1);
    end else if (!enable || timer == '0) begin
      timer <= TMW'(PERIOD - 1);
    end else begin
      timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Dropping enable aborts any burst in flight ahead of every other transition.
  always_comb begin
    state_n   = state;
    acc_add   = 1'b0;
    burst_clr = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    load_v    = 1'b0;
    publish   = 1'b0;
    set_err   = 1'b0;
    if (!enable && state != IDLE) begin
      state_n   = IDLE;
      burst_clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tick) state_n = START;
        end
        START: begin
          tmo_clr = 1'b1;
          state_n = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (adc.adc_done) begin
            acc_add = 1'b1;
            state_n = (cnt == CW'(NS - 1)) ? CONVERT : START;
          end else if (tmo_cnt == TOW'(TIMEOUT - 1)) begin
            set_err   = 1'b1;
            burst_clr = 1'b1;
            state_n   = IDLE;
          end else begin
            tmo_inc = 1'b1;
          end
        end
        CONVERT: begin
          load_v    = 1'b1;
          burst_clr = 1'b1;
          state_n   = SETTLE;
        end
        SETTLE: begin
          publish = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      tmo_cnt <= '0;
    end else begin
      if (burst_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (acc_add) begin
        acc <= acc + AW'(adc.adc_data);
        cnt <= cnt + 1'b1;
      end
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // CONVERT loads the average from the pre-clear accumulator value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_therm    <= '0;
      temp       <= '0;
      temp_valid <= 1'b0;
      adc_err    <= 1'b0;
    end else begin
      if (load_v) v_therm <= VW'(acc >> LOG2_AVG);
      if (publish) temp <= temp_therm;
      temp_valid <= publish;
      if (set_err)      adc_err <= 1'b1;
      else if (err_clr) adc_err <= 1'b0;
    end
  end

`ifdef THERM_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      over_temp <= 1'b0;
    end else if (publish) begin
      if (temp_therm >= TW'(ALARM_HI))      over_temp <= 1'b1;
      else if (temp_therm <= TW'(ALARM_LO)) over_temp <= 1'b0;
    end
  end
`else
  // Alarm thresholds only feed a constant here, so no comparator is built.
  localparam logic ALARM_CFG_OK = (ALARM_LO < ALARM_HI);
  assign over_temp = 1'b0 & ALARM_CFG_OK;
`endif

  assign adc.adc_start = (state == START);
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_therm_sample_ctrl.sv
// Directed bench for therm_sample_ctrl: ADC responder tasks, expected-value queue,
// immediate-assertion checks and a single summary line.
module tb_therm_sample_ctrl;
  localparam int VW       = 12;
  localparam int TW       = 8;
  localparam int PERIOD   = 40;
  localparam int LOG2_AVG = 2;
  localparam int TIMEOUT  = 64;
  localparam int ALARM_HI = 85;
  localparam int ALARM_LO = 80;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          err_clr;
  logic [VW-1:0] v_therm;
  logic [TW-1:0] temp_therm;
  logic [TW-1:0] temp;
  logic          temp_valid;
  logic          busy;
  logic          adc_err;
  logic          over_temp;
  logic [2:0]    dbg_state;

  therm_sample_ctrl_if #(.VW(VW)) adc_if ();

  therm_sample_ctrl #(
    .VW(VW), .TW(TW), .PERIOD(PERIOD), .LOG2_AVG(LOG2_AVG),
    .TIMEOUT(TIMEOUT), .ALARM_HI(ALARM_HI), .ALARM_LO(ALARM_LO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc(adc_if),
    .v_therm(v_therm), .temp_therm(temp_therm), .temp(temp),
    .temp_valid(temp_valid), .busy(busy), .adc_err(adc_err),
    .err_clr(err_clr), .over_temp(over_temp), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Converter stand-in: temperature code = v_therm / 4, truncated to TW bits.
  function automatic logic [TW-1:0] conv(input logic [VW-1:0] v);
    return TW'(v >> 2);
  endfunction

  assign temp_therm = conv(v_therm);

  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   exp_q[$];
  logic          ot_model = 1'b0;
  logic [VW-1:0] last_v = '0;
  logic [TW-1:0] last_t = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = (adc_if.adc_start === 1'b1);
    end
    chk("start_seen", 32'(ok), 32'd1);
  endtask

  // Called at the negedge of a start cycle s; done is driven in s+3 and the
  // task returns at the negedge of s+4 with done low again.
  task automatic adc_reply(input logic [VW-1:0] d);
    repeat (3) @(negedge clk);
    adc_if.adc_done = 1'b1;
    adc_if.adc_data = d;
    @(negedge clk);
    adc_if.adc_done = 1'b0;
    adc_if.adc_data = '0;
  endtask

  // Released at negedge r with enable high: starts must stay low until r+PERIOD.
  task automatic check_first_start();
    bit early = 1'b0;
    for (int k = 1; k < PERIOD; k++) begin
      @(negedge clk);
      if (adc_if.adc_start !== 1'b0) early = 1'b1;
    end
    chk("no_early_start", 32'(early), 32'd0);
    @(negedge clk);
    chk("first_start", 32'(adc_if.adc_start), 32'd1);
  endtask

  task automatic burst4(input bit at_start, input logic [VW-1:0] d0, d1, d2, d3);
    logic [VW-1:0] d [4];
    logic [VW+1:0] sum;
    logic [VW-1:0] ev;
    logic [TW-1:0] et;
    bit            ok;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    sum = (VW+2)'(d0) + (VW+2)'(d1) + (VW+2)'(d2) + (VW+2)'(d3);
    ev  = VW'(sum / 4);
    et  = conv(ev);
    exp_q.push_back(32'(ev));
    exp_q.push_back(32'(et));
`ifdef THERM_ALARM_EN
    if (et >= TW'(ALARM_HI))      ot_model = 1'b1;
    else if (et <= TW'(ALARM_LO)) ot_model = 1'b0;
`endif
    if (!at_start) begin
      wait_start(ok);
      if (!ok) begin
        exp_q.delete();
        return;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk("start_after_done", 32'(adc_if.adc_start), 32'd1);
      adc_reply(d[i]);
    end
    chk("state_convert", 32'(dbg_state), 32'd3);
    chk("valid_early", 32'(temp_valid), 32'd0);
    @(negedge clk);
    chk("v_therm", 32'(v_therm), exp_q.pop_front());
    @(negedge clk);
    chk("temp_valid", 32'(temp_valid), 32'd1);
    chk("temp", 32'(temp), exp_q.pop_front());
    chk("over_temp", 32'(over_temp), 32'(ot_model));
    @(negedge clk);
    chk("valid_pulse", 32'(temp_valid), 32'd0);
    last_v = ev;
    last_t = et;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit bad_busy;
    bit bad_err;
    bit tv_seen;

    rst_n = 1'b0;
    enable = 1'b0;
    err_clr = 1'b0;
    adc_if.adc_done = 1'b0;
    adc_if.adc_data = '0;
    repeat (2) @(negedge clk);

    chk("rst_v_therm", 32'(v_therm), 32'd0);
    chk("rst_temp", 32'(temp), 32'd0);
    chk("rst_temp_valid", 32'(temp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_adc_err", 32'(adc_err), 32'd0);
    chk("rst_over_temp", 32'(over_temp), 32'd0);
    chk("rst_adc_start", 32'(adc_if.adc_start), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    rst_n = 1'b1;
    enable = 1'b1;
    check_first_start();
    burst4(1'b1, 12'd100, 12'd200, 12'd300, 12'd400);
    burst4(1'b0, 12'd1, 12'd1, 12'd1, 12'd2);
    burst4(1'b0, 12'd4095, 12'd4095, 12'd4095, 12'd4095);

    // Asynchronous reset while waiting for a conversion.
    wait_start(ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_v_therm", 32'(v_therm), 32'd0);
    chk("midrst_temp", 32'(temp), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_adc_start", 32'(adc_if.adc_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ot_model = 1'b0;
    last_v = '0;
    last_t = '0;
    check_first_start();

    // Timeout: answer the first start, stay silent after the second.
    adc_reply(12'd10);
    chk("timeout_start2", 32'(adc_if.adc_start), 32'd1);
    bad_busy = 1'b0;
    bad_err = 1'b0;
    tv_seen = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) bad_busy = 1'b1;
      if (adc_err !== 1'b0) bad_err = 1'b1;
      if (temp_valid !== 1'b0) tv_seen = 1'b1;
    end
    chk("timeout_busy_window", 32'(bad_busy), 32'd0);
    chk("timeout_err_early", 32'(bad_err), 32'd0);
    @(negedge clk);
    if (temp_valid !== 1'b0) tv_seen = 1'b1;
    chk("timeout_adc_err", 32'(adc_err), 32'd1);
    chk("timeout_idle", 32'(busy), 32'd0);
    chk("timeout_no_valid", 32'(tv_seen), 32'd0);
    chk("timeout_v_hold", 32'(v_therm), 32'd0);
    burst4(1'b0, 12'd8, 12'd8, 12'd8, 12'd8);
    chk("adc_err_sticky", 32'(adc_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(adc_err), 32'd0);

    // Abort: one sample accumulated, then enable drops mid-wait.
    wait_start(ok);
    adc_reply(12'd4000);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    adc_if.adc_done = 1'b1;
    adc_if.adc_data = 12'd4000;
    @(negedge clk);
    adc_if.adc_done = 1'b0;
    adc_if.adc_data = '0;
    tv_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (temp_valid !== 1'b0 || busy !== 1'b0) tv_seen = 1'b1;
    end
    chk("abort_quiet", 32'(tv_seen), 32'd0);
    chk("abort_v_hold", 32'(v_therm), 32'(last_v));
    chk("abort_temp_hold", 32'(temp), 32'(last_t));
    chk("abort_no_err", 32'(adc_err), 32'd0);
    enable = 1'b1;
    burst4(1'b0, 12'd20, 12'd20, 12'd20, 12'd24);

    // Published temperatures 84, 85, 82, 80.
    burst4(1'b0, 12'd336, 12'd336, 12'd336, 12'd336);
    burst4(1'b0, 12'd340, 12'd340, 12'd340, 12'd340);
    burst4(1'b0, 12'd328, 12'd328, 12'd328, 12'd328);
    burst4(1'b0, 12'd320, 12'd320, 12'd320, 12'd320);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/therm_sample_ctrl.md
# therm_sample_ctrl

Sequencer for the thermistor voltage-to-temperature path. It paces ADC conversions from a free-running period timer and averages a burst of 2^LOG2_AVG samples. It drives the averaged code onto the `voltage` converter's `v_therm` input, captures `temp_therm`, and publishes a validated temperature with an optional over-temperature flag. It sits between the ADC interface and the `voltage` converter instance.

## Interface
- VW, 12: ADC / `v_therm` width
- TW, 8: `temp_therm` / `temp` width
- PERIOD, 1000: cycles between burst ticks (≥ 2)
- LOG2_AVG, 2: samples per burst = 2^LOG2_AVG
- TIMEOUT, 64: max cycles in WAIT_DONE
- ALARM_HI, 85: over-temp set threshold (unsigned)
- ALARM_LO, 80: over-temp clear threshold (unsigned, < ALARM_HI)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run timer and bursts
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  conversion complete, qualifies adc_data
- adc_data  in  VW  ADC result
- v_therm  out  VW  registered average, to converter
- temp_therm  in  TW  converter result; combinational from v_therm
- temp  out  TW  published temperature
- temp_valid  out  1  one-cycle pulse on publish
- busy  out  1  FSM not IDLE
- adc_err  out  1  sticky timeout flag
- err_clr  in  1  clears adc_err
- over_temp  out  1  alarm with hysteresis

## Operation
- Reset: state IDLE; timer = PERIOD-1; accumulator, sample count, timeout count = 0. All outputs 0, including v_therm and temp.
- Timer: runs only while enable=1 and decrements every cycle. At 0 it asserts internal tick for one cycle and reloads to PERIOD-1. While enable=0 it is held at PERIOD-1.
- FSM states: IDLE, START, WAIT_DONE, CONVERT, SETTLE.
- IDLE: a tick with enable=1 moves to START. A tick while busy is dropped.
- START: adc_start=1 for this cycle only, then WAIT_DONE. Timeout count is cleared.
- WAIT_DONE: adc_done is sampled only in this state. On adc_done, acc += adc_data and count increments. If count reaches 2^LOG2_AVG, go to CONVERT; otherwise go to START.
- Timeout: if TIMEOUT cycles pass in WAIT_DONE without adc_done, set adc_err, clear acc and count, and go to IDLE. No publish occurs. If adc_done arrives on the final allowed cycle, the done wins.
- CONVERT: v_therm <= acc >> LOG2_AVG (truncating). acc and count are cleared. Go to SETTLE.
- SETTLE: the converter settles. At the end of this cycle, temp <= temp_therm and temp_valid <= 1. Go to IDLE.
- Widths: acc is VW+LOG2_AVG bits and cannot overflow.
- enable=0 in any non-IDLE state forces IDLE on the next edge. acc and count are cleared. v_therm and temp hold. No temp_valid is issued.
- err_clr clears adc_err. A timeout in the same cycle as err_clr takes priority, and adc_err stays 1.
- busy = (state != IDLE).

## Timing
- Tick in cycle t: adc_start high in cycle t+1.
- adc_done in cycle c (not last sample): next adc_start in cycle c+1.
- Last adc_done in cycle c: CONVERT in c+1, new v_therm in c+2 (SETTLE), temp and temp_valid=1 in c+3.
- First tick occurs PERIOD cycles after enable rises.
- Minimum burst length with zero-latency done is 2·2^LOG2_AVG + 2 cycles. PERIOD shorter than this drops ticks.
- adc_done outside WAIT_DONE, including the cycle adc_start is high, is ignored.
- Reset mid-burst takes effect immediately; no adc_start after release until the next tick.

## Configuration
- THERM_ALARM_EN defined: on each publish, over_temp is set if temp ≥ ALARM_HI and cleared if temp ≤ ALARM_LO; otherwise it holds. over_temp is reset to 0.
- THERM_ALARM_EN undefined: over_temp is tied 0, no comparators are built, and ALARM_HI/ALARM_LO are unused.

## Test plan
- Reset: assert rst_n mid-WAIT_DONE -> all outputs 0 in the same cycle; after release, no adc_start until PERIOD cycles after the first enabled cycle.
- Nominal burst: ADC done 3 cycles after each start with data 100, 200, 300, 400 -> 4 adc_start pulses, v_therm=250, one temp_valid exactly 3 cycles after the 4th done, temp equals the converter output for 250.
- Truncation: data 1, 1, 1, 2 -> v_therm=1. Data 4095 ×4 -> v_therm=4095.
- Timeout: ADC silent after the 2nd start -> adc_err=1 at the 64th WAIT_DONE cycle, no temp_valid, next tick starts a fresh burst. err_clr then drops adc_err.
- Abort: enable low during WAIT_DONE -> busy=0 next cycle, a later adc_done is ignored, v_therm and temp unchanged.
- Alarm (THERM_ALARM_EN): published temps 84, 85, 82, 80 -> over_temp 0, 1, 1, 0. Without the macro, over_temp stays 0.
